// File: rtl/buzzer_poly.sv
// Polyphonic buzzer: decodes 24-bit commands into CHANNELS square-wave voices,
// mixes them and emits a first-order sigma-delta bit stream on the sound bus.
module buzzer_poly #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned VOL_WIDTH = 3,
  parameter int unsigned TICK_DIV  = 1024,
  localparam int unsigned MIX_W    = VOL_WIDTH + $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [23:0]         in,
  output logic [7:0]          sound,
  output logic                pwm,
  output logic [CHANNELS-1:0] active,
  output logic [MIX_W-1:0]    mix
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [MIX_W:0] FULL_SCALE = (MIX_W + 1)'(CHANNELS * (2 ** VOL_WIDTH - 1));

  localparam logic [3:0] OpNote     = 4'd1;
  localparam logic [3:0] OpStop     = 4'd2;
  localparam logic [3:0] OpVol      = 4'd3;
  localparam logic [3:0] OpDuration = 4'd4;
  localparam logic [3:0] OpStopAll  = 4'd5;

  logic [3:0]  opcode;
  logic [3:0]  chan;
  logic [15:0] payload;
  assign opcode  = in[23:20];
  assign chan    = in[19:16];
  assign payload = in[15:0];

  logic [TICK_W-1:0]    tickCnt;
  logic                 tick;
  logic [DIV_WIDTH-1:0] div    [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt    [CHANNELS];
  logic [DIV_WIDTH-1:0] durCnt [CHANNELS];
  logic [DIV_WIDTH-1:0] durLen [CHANNELS];
  logic [VOL_WIDTH-1:0] vol    [CHANNELS];
  logic [CHANNELS-1:0]  phase;
  logic [CHANNELS-1:0]  cmdHit;
  logic                 stopAll;
  logic [MIX_W-1:0]     mixSum;
  logic [MIX_W-1:0]     acc;
  logic [MIX_W:0]       accSum;

  assign tick    = (tickCnt == TICK_W'(TICK_DIV - 1));
  assign stopAll = start && (opcode == OpStopAll);

  // A channel command replaces that channel's tick update for this cycle.
  always_comb begin
    cmdHit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmdHit[i] = start && (chan == 4'(i)) && (opcode >= OpNote) && (opcode <= OpDuration);
    end
  end

  always_comb begin
    mixSum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active[i] && phase[i]) mixSum = mixSum + MIX_W'(vol[i]);
    end
  end

  assign accSum = {1'b0, acc} + {1'b0, mix};
  assign sound  = {8{pwm}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      phase  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        div[i]    <= '0;
        cnt[i]    <= '0;
        durCnt[i] <= '0;
        durLen[i] <= '0;
        vol[i]    <= '1;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cmdHit[i]) begin
          case (opcode)
            OpNote: begin
              div[i]    <= DIV_WIDTH'(payload);
              cnt[i]    <= '0;
              durCnt[i] <= durLen[i];
              active[i] <= (payload != '0);
              phase[i]  <= (payload != '0);
            end
            OpStop: begin
              active[i] <= 1'b0;
              phase[i]  <= 1'b0;
            end
            OpVol:      vol[i]    <= payload[VOL_WIDTH-1:0];
            OpDuration: durLen[i] <= DIV_WIDTH'(payload);
            default: ;
          endcase
        end else if (tick && active[i]) begin
          if (cnt[i] == div[i] - DIV_WIDTH'(1)) begin
            cnt[i]   <= '0;
            phase[i] <= ~phase[i];
          end else begin
            cnt[i] <= cnt[i] + DIV_WIDTH'(1);
          end
          // durCnt of zero means the note plays until stopped.
          if (durCnt[i] != '0) begin
            durCnt[i] <= durCnt[i] - DIV_WIDTH'(1);
            if (durCnt[i] == DIV_WIDTH'(1)) begin
              active[i] <= 1'b0;
              phase[i]  <= 1'b0;
            end
          end
        end
        if (stopAll) begin
          active[i] <= 1'b0;
          phase[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix <= '0;
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      mix <= mixSum;
      if (accSum >= FULL_SCALE) begin
        acc <= MIX_W'(accSum - FULL_SCALE);
        pwm <= 1'b1;
      end else begin
        acc <= MIX_W'(accSum);
        pwm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_buzzer_poly.sv
// Bench for buzzer_poly: a behavioural model queues expected outputs per command
// cycle; each is popped and compared once the DUT has clocked.
module tb_buzzer_poly;

  localparam int unsigned CH    = 4;
  localparam int unsigned VW    = 3;
  localparam int unsigned TDIV  = 4;
  localparam int unsigned MIX_W = VW + $clog2(CH + 1);
  localparam int unsigned FS    = CH * (2 ** VW - 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [23:0]      cmd;
  logic [7:0]       sound;
  logic             pwm;
  logic [CH-1:0]    active;
  logic [MIX_W-1:0] mix;

  buzzer_poly #(
    .CHANNELS (CH),
    .DIV_WIDTH(16),
    .VOL_WIDTH(VW),
    .TICK_DIV (TDIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (cmd),
    .sound (sound),
    .pwm   (pwm),
    .active(active),
    .mix   (mix)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    act;
    logic [MIX_W-1:0] mix;
    logic             pwm;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int unsigned mTick;
  int unsigned mDiv[CH], mCnt[CH], mDur[CH], mDurLen[CH], mVol[CH];
  bit          mAct[CH], mPh[CH];
  int unsigned mMix, mAcc;
  bit          mPwm;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mkCmd(input int op, input int ch, input int pl);
    return {4'(op), 4'(ch), 16'(pl)};
  endfunction

  task automatic modelReset();
    mTick = 0; mMix = 0; mAcc = 0; mPwm = 0;
    for (int i = 0; i < CH; i++) begin
      mDiv[i] = 0; mCnt[i] = 0; mDur[i] = 0; mDurLen[i] = 0;
      mVol[i] = 2 ** VW - 1; mAct[i] = 0; mPh[i] = 0;
    end
  endtask

  task automatic modelStep(input bit st, input logic [23:0] c);
    int unsigned nCnt[CH], nDur[CH], nDiv[CH], nDurLen[CH], nVol[CH];
    bit          nAct[CH], nPh[CH];
    bit          tk;
    int unsigned sum, s, op, ch, pl;
    op = c[23:20]; ch = c[19:16]; pl = c[15:0];
    tk = (mTick == TDIV - 1);
    sum = 0;
    for (int i = 0; i < CH; i++) if (mAct[i] && mPh[i]) sum += mVol[i];
    s = mAcc + mMix;
    if (s >= FS) begin mAcc = s - FS; mPwm = 1; end
    else begin mAcc = s; mPwm = 0; end
    for (int i = 0; i < CH; i++) begin
      nCnt[i] = mCnt[i]; nDur[i] = mDur[i]; nDiv[i] = mDiv[i];
      nDurLen[i] = mDurLen[i]; nVol[i] = mVol[i]; nAct[i] = mAct[i]; nPh[i] = mPh[i];
      if (tk && mAct[i]) begin
        if (mCnt[i] + 1 == mDiv[i]) begin nCnt[i] = 0; nPh[i] = !mPh[i]; end
        else nCnt[i] = mCnt[i] + 1;
        if (mDur[i] != 0) begin
          nDur[i] = mDur[i] - 1;
          if (mDur[i] == 1) begin nAct[i] = 0; nPh[i] = 0; end
        end
      end
    end
    if (st && ch < CH && op >= 1 && op <= 4) begin
      nCnt[ch] = mCnt[ch]; nDur[ch] = mDur[ch]; nPh[ch] = mPh[ch]; nAct[ch] = mAct[ch];
      case (op)
        1: begin
          nDiv[ch] = pl; nCnt[ch] = 0; nDur[ch] = mDurLen[ch];
          nAct[ch] = (pl != 0); nPh[ch] = (pl != 0);
        end
        2: begin nAct[ch] = 0; nPh[ch] = 0; end
        3: nVol[ch] = pl % (2 ** VW);
        default: nDurLen[ch] = pl;
      endcase
    end
    if (st && op == 5) for (int i = 0; i < CH; i++) begin nAct[i] = 0; nPh[i] = 0; end
    for (int i = 0; i < CH; i++) begin
      mCnt[i] = nCnt[i]; mDur[i] = nDur[i]; mDiv[i] = nDiv[i]; mDurLen[i] = nDurLen[i];
      mVol[i] = nVol[i]; mAct[i] = nAct[i]; mPh[i] = nPh[i];
    end
    mTick = tk ? 0 : mTick + 1;
    mMix = sum;
  endtask

  // Drive one cycle, queue the model's expectation, then compare after the edge.
  task automatic cycle(input bit st, input logic [23:0] c);
    exp_t e;
    start = st;
    cmd   = c;
    modelStep(st, c);
    for (int i = 0; i < CH; i++) e.act[i] = mAct[i];
    e.mix = MIX_W'(mMix);
    e.pwm = mPwm;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkVal("active", 32'(active), 32'(e.act));
    checkVal("mix", 32'(mix), 32'(e.mix));
    checkVal("pwm", 32'(pwm), 32'(e.pwm));
    checkVal("sound", 32'(sound), 32'({8{e.pwm}}));
    start = 1'b0;
    cmd   = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 24'h0);
  endtask

  int pwmCount;
  int actCount;

  initial begin
    rst = 1'b1; start = 1'b0; cmd = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_active", 32'(active), 32'h0);
    checkVal("reset_mix", 32'(mix), 32'h0);
    checkVal("reset_pwm", 32'(pwm), 32'h0);
    rst = 1'b0;

    idle(5000);
    checkVal("idle_active", 32'(active), 32'h0);

    // Single voice: half period of 3 ticks at full reset volume.
    cycle(1'b1, mkCmd(1, 0, 3));
    checkVal("note_active_next", 32'(active[0]), 32'h1);
    cycle(1'b0, 24'h0);
    checkVal("note_mix_vol", 32'(mix), 32'd7);
    idle(40);

    // Timed note on ch1, then a repeat that reuses the stored length.
    cycle(1'b1, mkCmd(4, 1, 10));
    cycle(1'b1, mkCmd(1, 1, 2));
    actCount = 0;
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, 24'h0);
      if (active[1]) actCount++;
    end
    checkVal("dur_bounded", 32'(actCount >= 36 && actCount <= 40), 32'h1);
    cycle(1'b1, mkCmd(1, 1, 2));
    idle(60);
    checkVal("dur_repeat_off", 32'(active[1]), 32'h0);

    // Two voices, ch1 at volume 3: mix 10 of 28, 100 pulses per 280 clocks.
    cycle(1'b1, mkCmd(5, 0, 0));
    cycle(1'b1, mkCmd(4, 1, 0));
    cycle(1'b1, mkCmd(1, 0, 1000));
    cycle(1'b1, mkCmd(1, 1, 1000));
    cycle(1'b1, mkCmd(3, 1, 3));
    idle(5);
    checkVal("mix_two_voice", 32'(mix), 32'd10);
    pwmCount = 0;
    for (int k = 0; k < 280; k++) begin
      cycle(1'b0, 24'h0);
      if (pwm) pwmCount++;
    end
    checkVal("pwm_density", 32'(pwmCount), 32'd100);

    // Out-of-range channel and unknown opcode leave state untouched.
    cycle(1'b1, mkCmd(1, 9, 50));
    cycle(1'b1, mkCmd(7, 2, 50));
    checkVal("ignored_cmds", 32'(active), 32'h3);
    cycle(1'b1, mkCmd(1, 2, 0));
    checkVal("note_zero", 32'(active[2]), 32'h0);
    cycle(1'b1, mkCmd(1, 2, 500));
    idle(3);
    checkVal("three_voices", 32'(active), 32'h7);
    cycle(1'b1, mkCmd(5, 3, 0));
    checkVal("stopall_active", 32'(active), 32'h0);
    cycle(1'b0, 24'h0);
    checkVal("stopall_mix", 32'(mix), 32'h0);
    idle(30);
    checkVal("stopall_pwm", 32'(pwm), 32'h0);

    // Asynchronous reset in the middle of a note.
    cycle(1'b1, mkCmd(1, 0, 5));
    idle(20);
    checkVal("pre_reset_active", 32'(active[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkVal("async_active", 32'(active), 32'h0);
    checkVal("async_mix", 32'(mix), 32'h0);
    checkVal("async_pwm", 32'(pwm), 32'h0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(200);
    checkVal("post_reset_silent", 32'(active), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buzzer_poly.md
Name: buzzer_poly

Overview:
- Parametrised, polyphonic successor to the single-voice buzzer command path.
- Decodes 24-bit buzzer commands and drives CHANNELS independent square-wave tone voices, each with per-channel volume and optional note duration.
- Sums all voices into a mix level and converts it to a 1-bit first-order sigma-delta stream, replicated onto the 8-bit sound bus.
- Sits between the CPU command port and the board buzzer pins.

Parameters:
- CHANNELS, 4: number of tone voices, 1..16.
- DIV_WIDTH, 16: width of the half-period divider and the duration counters.
- VOL_WIDTH, 3: per-channel volume width.
- TICK_DIV, 1024: clk cycles per sample tick, >=2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  command strobe; one command per cycle.
- in  in  24  command: in[23:20] opcode, in[19:16] channel, in[15:0] payload.
- sound  out  8  pwm replicated on all 8 bits.
- pwm  out  1  sigma-delta bit stream.
- active  out  CHANNELS  per-channel voice active.
- mix  out  MIX_W  registered voice sum; MIX_W = VOL_WIDTH + clog2(CHANNELS+1).

Behaviour:
- Reset values (async, immediate): pwm=0, sound=0, active=0, mix=0.
- Reset internal state: all div/cnt/phase/dur registers = 0; channel volumes = 2^VOL_WIDTH-1; tick counter = 0; sigma-delta accumulator = 0.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for one clk when it wraps to 0.
- Command decode, only when start=1 and channel < CHANNELS (otherwise ignored, no state change):
  - Opcode 0, NOP: no effect.
  - Opcode 1, NOTE: div <= payload[DIV_WIDTH-1:0]; cnt <= 0; phase <= 1; dur_cnt <= dur_len; active <= (payload != 0). payload 0 behaves as STOP.
  - Opcode 2, STOP: active <= 0; phase <= 0.
  - Opcode 3, VOL: vol <= payload[VOL_WIDTH-1:0].
  - Opcode 4, DURATION: dur_len <= payload. 0 = infinite. Affects later NOTEs only.
  - Opcode 5, STOPALL: every channel active <= 0; phase <= 0. Channel field ignored.
  - Other opcodes: ignored.
- Command takes effect at the clock edge where start is sampled; active is visible the next cycle.
- Voice, on tick while active:
  - If cnt == div-1: cnt <= 0 and phase toggles; else cnt <= cnt+1. Half period = div ticks.
  - If dur_len != 0: dur_cnt decrements. On the tick where dur_cnt == 1: active <= 0, phase <= 0.
- Simultaneous events: a command addressed to a channel on the same cycle as that channel's tick update wins; the tick update for that channel is discarded. STOPALL overrides everything.
- Mixer: every clk, mix <= sum of vol[i] over channels with active[i] & phase[i]. Latency 1 clk. Full scale FS = CHANNELS*(2^VOL_WIDTH-1).
- Sigma-delta, every clk:
  - If acc + mix >= FS: acc <= acc + mix - FS and pwm <= 1.
  - Else: acc <= acc + mix and pwm <= 0.
  - Result: pwm density = mix/FS. mix = 0 gives constant 0; mix = FS gives constant 1.
- Reset asserted mid-note: everything returns to reset values immediately; no note resumes after release.

Test Plan:
- Release reset, idle 5000 clks -> active=0, mix=0, pwm=0; channel volumes read back via mix = 7 after a NOTE.
- TICK_DIV=4: NOTE ch0 payload 3 -> active[0]=1 next clk; phase toggles every 12 clks; mix alternates 7 and 0 every 12 clks.
- DURATION ch1 payload 10, then NOTE ch1 payload 2 -> active[1] drops after exactly 10 ticks (40 clks); later NOTE ch1 also lasts 10 ticks.
- CHANNELS=4: NOTE ch0 and ch1 with payload 1000 (both phase high), VOL ch1 payload 3 -> mix=10; over 280 clks pwm high exactly 100 times (FS=28).
- NOTE on channel 9 and opcode 7 -> no change in active/mix. NOTE ch2 payload 0 -> active[2]=0. STOPALL while 3 voices play -> active=0, mix=0 one clk later, pwm settles to 0.
- Assert rst for 1 clk mid-note -> pwm/mix/active=0 asynchronously; after release, no output until a new NOTE.
